// File: rtl/seq_divider_if.sv
// Handshake/result bundle for seq_divider.
// master: the requester driving start and operands; slave: the divider.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider: one shift-subtract step per clock over WIDTH
// clocks, IDLE -> RUN -> DONE, with a one-cycle done pulse and held results.
// Divide by zero bypasses the iterations and reports all-ones / dividend.
// Optional build macro SEQ_DIVIDER_SIGNED_EN: two's complement operands,
// truncating division; magnitudes are divided and signs restored on entry
// to DONE, so latency is identical in both builds.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] rem_acc_reg;   // partial remainder
  logic [WIDTH-1:0] q_acc_reg;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_reg;       // divisor magnitude
  logic             dz_reg;        // sampled divisor was zero
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             div_by_zero_reg;

  // One restoring step: shift in the next dividend bit, trial-subtract.
  // The partial remainder stays below the divisor, so the borrow bit of
  // the (WIDTH+1)-bit difference alone decides whether the subtract fits.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  assign shifted = {rem_acc_reg, q_acc_reg[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_reg};

  // Operand magnitudes at acceptance and sign-corrected results at DONE.
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] dz_r;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_a_reg;
  logic neg_b_reg;
  // Negating the most-negative value yields itself, which read as unsigned
  // is the correct magnitude; that also makes MIN / -1 fall out as MIN.
  assign mag_a = bus.dividend[WIDTH-1] ? (WIDTH'(0) - bus.dividend) : bus.dividend;
  assign mag_b = bus.divisor[WIDTH-1]  ? (WIDTH'(0) - bus.divisor)  : bus.divisor;
  assign res_q = (neg_a_reg ^ neg_b_reg) ? (WIDTH'(0) - q_acc_reg) : q_acc_reg;
  assign res_r = neg_a_reg ? (WIDTH'(0) - rem_acc_reg) : rem_acc_reg;
  // On divide by zero q_acc_reg still holds the dividend magnitude.
  assign dz_r  = neg_a_reg ? (WIDTH'(0) - q_acc_reg) : q_acc_reg;

  // Operand signs captured with the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_a_reg <= 1'b0;
      neg_b_reg <= 1'b0;
    end else if ((state_reg != RUN) && bus.start) begin
      neg_a_reg <= bus.dividend[WIDTH-1];
      neg_b_reg <= bus.divisor[WIDTH-1];
    end
  end
`else
  assign mag_a = bus.dividend;
  assign mag_b = bus.divisor;
  assign res_q = q_acc_reg;
  assign res_r = rem_acc_reg;
  assign dz_r  = q_acc_reg;
`endif

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      count_reg       <= '0;
      rem_acc_reg     <= '0;
      q_acc_reg       <= '0;
      dvs_reg         <= '0;
      dz_reg          <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      quotient_reg    <= '0;
      remainder_reg   <= '0;
      div_by_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (dz_reg || (count_reg == '0)) begin
            state_reg       <= DONE;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b1;
            div_by_zero_reg <= dz_reg;
            quotient_reg    <= dz_reg ? '1 : res_q;
            remainder_reg   <= dz_reg ? dz_r : res_r;
          end else begin
            count_reg   <= count_reg - 1'b1;
            q_acc_reg   <= {q_acc_reg[WIDTH-2:0], ~diff[WIDTH]};
            rem_acc_reg <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          end
        end
        default: begin  // IDLE and DONE both accept a new request
          done_reg <= 1'b0;
          if (bus.start) begin
            state_reg   <= RUN;
            busy_reg    <= 1'b1;
            count_reg   <= CNT_W'(WIDTH);
            q_acc_reg   <= mag_a;
            dvs_reg     <= mag_b;
            rem_acc_reg <= '0;
            dz_reg      <= (bus.divisor == '0);
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = div_by_zero_reg;

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result bit width (legal range 2..32).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 start  input  1  request pulse; operands are sampled when the block accepts the request.
REQ-005 dividend  input  WIDTH  numerator.
REQ-006 divisor  input  WIDTH  denominator.
REQ-007 busy  output  1  high while a division is in progress.
REQ-008 done  output  1  one-cycle pulse; results are valid in that cycle.
REQ-009 quotient  output  WIDTH  result quotient.
REQ-010 remainder  output  WIDTH  result remainder.
REQ-011 div_by_zero  output  1  high with results when the sampled divisor was 0.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
REQ-013 In IDLE or DONE, start=1 SHALL be accepted: operands latched internally, iteration counter loaded with WIDTH, next state RUN, busy=1.
REQ-014 In RUN, start SHALL be ignored, and changes on dividend/divisor SHALL have no effect.
REQ-015 RUN SHALL perform one restoring shift-subtract step per cycle over WIDTH cycles, then go to DONE.
REQ-016 Latency: if start is accepted at edge N, done=1 SHALL be seen in the cycle after edge N+WIDTH+1.
REQ-017 DONE SHALL last exactly one cycle: done=1 and busy=0; the next state is IDLE, or RUN if start=1 in that cycle.
REQ-018 quotient, remainder and div_by_zero SHALL update only on the transition into DONE, and SHALL hold until the next DONE.
REQ-019 The block SHALL compute unsigned quotient = floor(dividend/divisor) and remainder = dividend - quotient*divisor, both exactly WIDTH bits.
REQ-020 Divisor 0 at acceptance SHALL skip RUN and go to DONE on the next edge, with quotient all ones, remainder = dividend and div_by_zero=1.
REQ-021 div_by_zero SHALL be 0 for every non-zero divisor.
REQ-022 dividend < divisor SHALL give quotient 0 and remainder = dividend, with normal latency.

Reset
REQ-023 rst_n=0 SHALL immediately force the state to IDLE and clear busy, done, quotient, remainder, div_by_zero and the counter to 0.
REQ-024 Reset during RUN SHALL abort the operation with no done pulse.
REQ-025 The first start after rst_n goes high SHALL be accepted on the next rising edge.

Configuration
REQ-026 Macro SEQ_DIVIDER_SIGNED_EN, when defined, SHALL treat operands and results as two's complement.
REQ-027 In signed mode, division SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend (or be 0).
REQ-028 In signed mode, most-negative / -1 SHALL give quotient = most-negative and remainder 0, with div_by_zero=0.
REQ-029 In signed mode, divisor 0 SHALL give quotient all ones (-1), remainder = dividend and div_by_zero=1.
REQ-030 In signed mode, latency SHALL be unchanged: sign fix-up happens on the transition into DONE.
REQ-031 When the macro is undefined, the block SHALL be unsigned only, with no sign logic synthesised.

Verification
REQ-032 WIDTH=4, unsigned: 10/3, start at edge 0 -> done in the cycle after edge 5; quotient=3, remainder=1, div_by_zero=0.
REQ-033 WIDTH=8: 200/0 -> done one cycle after acceptance; quotient=0xFF, remainder=200, div_by_zero=1.
REQ-034 WIDTH=8: 255/1 and 7/9 -> quotient=255, remainder=0; then quotient=0, remainder=7.
REQ-035 WIDTH=8: start re-pulsed with new operands during RUN -> ignored, original result returned; start held in the DONE cycle -> back-to-back op accepted.
REQ-036 rst_n pulsed low at RUN cycle 3 -> outputs 0 at once, no done pulse; a new start afterwards completes correctly.
REQ-037 With SEQ_DIVIDER_SIGNED_EN, WIDTH=8: -7/2 -> quotient=-3, remainder=-1; -128/-1 -> quotient=-128, remainder=0.
